reg_file_pair_idu: RTL and testbench
====================================

// Module: reg_file_pair_idu
// PURPOSE
//  Parametrised successor to the CPU register file: NUM_PAIRS byte-pairs plus SP and PC,
//  two 8-bit read ports, one 16-bit read port, independent 8/16-bit write ports and an
//  integrated 16-bit increment/decrement unit (IDU) with same-cycle writeback.
//  Sits between the control sequencer and the ALU/address bus in the CPU datapath.
// PARAMETERS
//  DATA_W     8        width of one byte register; pairs, SP and PC are 2*DATA_W
//  NUM_PAIRS  4        number of byte pairs (default order WZ,BC,DE,HL)
//  SP_RESET   16'hFFFE SP value after reset (truncated/zero-extended to 2*DATA_W)
//  PC_RESET   16'h0000 PC value after reset
//  (local) SEL8_W=clog2(2*NUM_PAIRS), SEL16_W=clog2(NUM_PAIRS+2)
// PORTS
//  i_Clk        in   1         system clock, all state on rising edge
//  i_Reset      in   1         synchronous, active-high reset
//  i_Enable     in   1         tick enable; low = no state change
//  i_Rd8A_Sel   in   SEL8_W    byte select, port A (even=high byte, odd=low byte of pair sel/2)
//  o_Rd8A       out  DATA_W    byte read data, port A
//  i_Rd8B_Sel   in   SEL8_W    byte select, port B
//  o_Rd8B       out  DATA_W    byte read data, port B
//  i_Wr8_En     in   1         byte write strobe
//  i_Wr8_Sel    in   SEL8_W    byte write target
//  i_Wr8_Data   in   DATA_W    byte write data
//  i_Rd16_Sel   in   SEL16_W   word select: 0..NUM_PAIRS-1 pairs, NUM_PAIRS=SP, NUM_PAIRS+1=PC
//  o_Rd16       out  2*DATA_W  word read data
//  i_Wr16_En    in   1         word write strobe
//  i_Wr16_Sel   in   SEL16_W   word write target
//  i_Wr16_Data  in   2*DATA_W  word write data
//  i_Idu_En     in   1         IDU strobe
//  i_Idu_Sel    in   SEL16_W   IDU target word
//  i_Idu_Dec    in   1         0 = +1, 1 = -1
//  o_Idu_Addr   out  2*DATA_W  pre-update value of IDU target (drives address bus)
// BEHAVIOUR
//  - Reads combinational; out-of-range select reads 0. o_Idu_Addr combinational from i_Idu_Sel.
//  - Reset (overrides i_Enable): all pair bytes 0, SP=SP_RESET, PC=PC_RESET, next edge.
//  - i_Enable=0: every write and IDU strobe ignored; reads still valid.
//  - Writes commit on rising edge; out-of-range write/IDU select ignored, no side effect.
//  - IDU: target <= target +/- 1 mod 2^(2*DATA_W); 0xFFFF+1 -> 0x0000, 0x0000-1 -> 0xFFFF;
//    carry propagates across both bytes of a pair. Latency 1 cycle.
//  - Independent targets: Wr8, Wr16 and IDU all commit in the same cycle.
//  - Collision priority per byte: Wr16 > IDU > Wr8 (e.g. Wr8 to H + IDU on HL: IDU wins both
//    bytes; Wr8 to H + Wr16 to DE: both commit).
//  - No internal FSM beyond the storage; update logic is pure next-state per register.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: read ports forward the value committing this cycle (after
//    priority resolution) when sel matches a written/IDU target; o_Idu_Addr is NOT
//    bypassed (always pre-update). Forwarding gated by i_Enable and suppressed in reset.
//  Undefined: reads return the stored (pre-edge) value only.
// TESTING
//  1 Reset: i_Reset=1 one edge -> o_Rd16(sel SP)=FFFE, PC=0000, all bytes read 00.
//  2 Wr16 BC=0x1234 -> Rd8A sel2=12, Rd8B sel3=34, Rd16 sel1=1234 next cycle.
//  3 HL=0xFFFF, IDU inc on HL -> o_Idu_Addr=FFFF that cycle, HL=0000 next; DEC from 0000 -> FFFF.
//  4 Same edge Wr8 H=AA, IDU inc HL (HL=0x10FF) -> HL=1100; Wr16 HL=BEEF + IDU HL -> BEEF.
//  5 i_Enable=0 with Wr8/Wr16/IDU strobes -> no register changes; reset with i_Enable=0 still applies.
//  6 BYPASS_EN: Wr8 E=5A, Rd8A sel5 same cycle -> 5A; without macro -> old value.

Source files
------------

// File: rtl/reg_file_pair_idu.sv
// reg_file_pair_idu: NUM_PAIRS byte-pair registers plus SP and PC.
// Provides two byte read ports, one word read port, independent byte and word
// write ports, and a 16-bit increment/decrement unit whose result is written
// back on the same edge.
// Optional build macro REGFILE_BYPASS_EN: read ports forward the value that
// commits on the coming edge. o_Idu_Addr always shows the stored value.
module reg_file_pair_idu #(
  parameter int unsigned  DATA_W    = 8,
  parameter int unsigned  NUM_PAIRS = 4,
  parameter logic [15:0]  SP_RESET  = 16'hFFFE,
  parameter logic [15:0]  PC_RESET  = 16'h0000,
  localparam int unsigned SEL8_W    = $clog2(2*NUM_PAIRS),
  localparam int unsigned SEL16_W   = $clog2(NUM_PAIRS+2)
) (
  input  logic                i_Clk,
  input  logic                i_Reset,
  input  logic                i_Enable,
  input  logic [SEL8_W-1:0]   i_Rd8A_Sel,
  output logic [DATA_W-1:0]   o_Rd8A,
  input  logic [SEL8_W-1:0]   i_Rd8B_Sel,
  output logic [DATA_W-1:0]   o_Rd8B,
  input  logic                i_Wr8_En,
  input  logic [SEL8_W-1:0]   i_Wr8_Sel,
  input  logic [DATA_W-1:0]   i_Wr8_Data,
  input  logic [SEL16_W-1:0]  i_Rd16_Sel,
  output logic [2*DATA_W-1:0] o_Rd16,
  input  logic                i_Wr16_En,
  input  logic [SEL16_W-1:0]  i_Wr16_Sel,
  input  logic [2*DATA_W-1:0] i_Wr16_Data,
  input  logic                i_Idu_En,
  input  logic [SEL16_W-1:0]  i_Idu_Sel,
  input  logic                i_Idu_Dec,
  output logic [2*DATA_W-1:0] o_Idu_Addr
);

  localparam int unsigned WW = 2*DATA_W;
  localparam int unsigned NW = NUM_PAIRS + 2;
  localparam int unsigned SP_IDX = NUM_PAIRS;
  localparam int unsigned PC_IDX = NUM_PAIRS + 1;
  localparam logic [WW-1:0] SP_RST_W = WW'(SP_RESET);
  localparam logic [WW-1:0] PC_RST_W = WW'(PC_RESET);
  localparam logic [WW-1:0] ONE_W    = WW'(1);

  // Word storage: indices 0..NUM_PAIRS-1 are pairs, then SP, then PC.
  // Within a pair, the high byte is byte select 2*w, the low byte 2*w+1.
  logic [WW-1:0] words_q [NW];
  logic [WW-1:0] words_d [NW];
  logic [WW-1:0] rd_words [NW];

  // Next-state per word. Assignment order encodes per-byte priority
  // Wr16 > IDU > Wr8; IDU replaces both bytes of its target.
  always_comb begin
    for (int unsigned w = 0; w < NW; w++) begin
      words_d[w] = words_q[w];
      if (i_Enable) begin
        if (w < NUM_PAIRS) begin
          if (i_Wr8_En && (i_Wr8_Sel == SEL8_W'(2*w)))
            words_d[w][WW-1:DATA_W] = i_Wr8_Data;
          if (i_Wr8_En && (i_Wr8_Sel == SEL8_W'(2*w+1)))
            words_d[w][DATA_W-1:0] = i_Wr8_Data;
        end
        if (i_Idu_En && (i_Idu_Sel == SEL16_W'(w)))
          words_d[w] = i_Idu_Dec ? (words_q[w] - ONE_W) : (words_q[w] + ONE_W);
        if (i_Wr16_En && (i_Wr16_Sel == SEL16_W'(w)))
          words_d[w] = i_Wr16_Data;
      end
    end
  end

  // Register update with synchronous reset overriding the enable.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      for (int unsigned w = 0; w < NW; w++) begin
        if (w == SP_IDX)      words_q[w] <= SP_RST_W;
        else if (w == PC_IDX) words_q[w] <= PC_RST_W;
        else                  words_q[w] <= '0;
      end
    end else begin
      for (int unsigned w = 0; w < NW; w++)
        words_q[w] <= words_d[w];
    end
  end

  // Source view for the read ports: stored values, or the committing values
  // when forwarding is built in (words_d already folds in i_Enable).
  always_comb begin
    for (int unsigned w = 0; w < NW; w++) begin
`ifdef REGFILE_BYPASS_EN
      rd_words[w] = i_Reset ? words_q[w] : words_d[w];
`else
      rd_words[w] = words_q[w];
`endif
    end
  end

  // Combinational read muxes; unmatched selects read zero.
  always_comb begin
    o_Rd8A     = '0;
    o_Rd8B     = '0;
    o_Rd16     = '0;
    o_Idu_Addr = '0;
    for (int unsigned w = 0; w < NW; w++) begin
      if (w < NUM_PAIRS) begin
        if (i_Rd8A_Sel == SEL8_W'(2*w))   o_Rd8A = rd_words[w][WW-1:DATA_W];
        if (i_Rd8A_Sel == SEL8_W'(2*w+1)) o_Rd8A = rd_words[w][DATA_W-1:0];
        if (i_Rd8B_Sel == SEL8_W'(2*w))   o_Rd8B = rd_words[w][WW-1:DATA_W];
        if (i_Rd8B_Sel == SEL8_W'(2*w+1)) o_Rd8B = rd_words[w][DATA_W-1:0];
      end
      if (i_Rd16_Sel == SEL16_W'(w)) o_Rd16     = rd_words[w];
      if (i_Idu_Sel  == SEL16_W'(w)) o_Idu_Addr = words_q[w];
    end
  end

endmodule

// File: tb/tb_reg_file_pair_idu.sv
// Directed bench for reg_file_pair_idu (default parameters: 4 pairs, 8-bit).
module tb_reg_file_pair_idu;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [2:0]  rd8a_sel, rd8b_sel, wr8_sel, rd16_sel, wr16_sel, idu_sel;
  logic [7:0]  rd8a, rd8b, wr8_data;
  logic [15:0] rd16, wr16_data, idu_addr;
  logic        wr8_en, wr16_en, idu_en, idu_dec;

  int total = 0;
  int bad   = 0;

  reg_file_pair_idu dut (
    .i_Clk       (clk),
    .i_Reset     (rst),
    .i_Enable    (en),
    .i_Rd8A_Sel  (rd8a_sel),
    .o_Rd8A      (rd8a),
    .i_Rd8B_Sel  (rd8b_sel),
    .o_Rd8B      (rd8b),
    .i_Wr8_En    (wr8_en),
    .i_Wr8_Sel   (wr8_sel),
    .i_Wr8_Data  (wr8_data),
    .i_Rd16_Sel  (rd16_sel),
    .o_Rd16      (rd16),
    .i_Wr16_En   (wr16_en),
    .i_Wr16_Sel  (wr16_sel),
    .i_Wr16_Data (wr16_data),
    .i_Idu_En    (idu_en),
    .i_Idu_Sel   (idu_sel),
    .i_Idu_Dec   (idu_dec),
    .o_Idu_Addr  (idu_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr8_en = 1'b0; wr16_en = 1'b0; idu_en = 1'b0; idu_dec = 1'b0;
  endtask

  task automatic rd16_at(input logic [2:0] s, input string tag, input logic [15:0] exp);
    rd16_sel = s;
    #1;
    chk(tag, rd16, exp);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0;
    rd8a_sel = '0; rd8b_sel = '0; rd16_sel = '0;
    wr8_sel = '0; wr8_data = '0; wr16_sel = '0; wr16_data = '0; idu_sel = '0;
    idle();

    // Reset applies even with enable low.
    tick();
    rst = 1'b0;
    rd16_at(3'd4, "rst_sp", 16'hFFFE);
    rd16_at(3'd5, "rst_pc", 16'h0000);
    for (int i = 0; i < 8; i++) begin
      rd8a_sel = 3'(i);
      #1;
      chk($sformatf("rst_byte%0d", i), {8'h00, rd8a}, 16'h0000);
    end

    // Word write to BC, read back through all three ports.
    en = 1'b1;
    wr16_en = 1'b1; wr16_sel = 3'd1; wr16_data = 16'h1234;
    tick(); idle();
    rd8a_sel = 3'd2; rd8b_sel = 3'd3; #1;
    chk("bc_hi_a", {8'h00, rd8a}, 16'h0012);
    chk("bc_lo_b", {8'h00, rd8b}, 16'h0034);
    rd16_at(3'd1, "bc_word", 16'h1234);

    // IDU wrap: FFFF+1 and 0000-1 on HL.
    wr16_en = 1'b1; wr16_sel = 3'd3; wr16_data = 16'hFFFF;
    tick(); idle();
    idu_en = 1'b1; idu_sel = 3'd3; idu_dec = 1'b0; #1;
    chk("idu_addr_ffff", idu_addr, 16'hFFFF);
    tick(); idle();
    rd16_at(3'd3, "hl_inc_wrap", 16'h0000);
    idu_en = 1'b1; idu_sel = 3'd3; idu_dec = 1'b1; #1;
    chk("idu_addr_0000", idu_addr, 16'h0000);
    tick(); idle();
    rd16_at(3'd3, "hl_dec_wrap", 16'hFFFF);

    // Collisions: IDU beats Wr8 on both bytes; Wr16 beats IDU and Wr8.
    wr16_en = 1'b1; wr16_sel = 3'd3; wr16_data = 16'h10FF;
    tick(); idle();
    wr8_en = 1'b1; wr8_sel = 3'd6; wr8_data = 8'hAA;
    idu_en = 1'b1; idu_sel = 3'd3; idu_dec = 1'b0;
    tick(); idle();
    rd16_at(3'd3, "wr8_vs_idu", 16'h1100);
    wr16_en = 1'b1; wr16_sel = 3'd3; wr16_data = 16'hBEEF;
    idu_en = 1'b1; idu_sel = 3'd3;
    wr8_en = 1'b1; wr8_sel = 3'd7; wr8_data = 8'h11;
    tick(); idle();
    rd16_at(3'd3, "wr16_vs_idu", 16'hBEEF);
    // Independent targets commit together.
    wr8_en = 1'b1; wr8_sel = 3'd6; wr8_data = 8'hAA;
    wr16_en = 1'b1; wr16_sel = 3'd2; wr16_data = 16'hCAFE;
    idu_en = 1'b1; idu_sel = 3'd4; idu_dec = 1'b1;
    tick(); idle();
    rd16_at(3'd3, "indep_hl", 16'hAAEF);
    rd16_at(3'd2, "indep_de", 16'hCAFE);
    rd16_at(3'd4, "sp_dec", 16'hFFFD);
    idu_en = 1'b1; idu_sel = 3'd5; idu_dec = 1'b0;
    tick(); idle();
    rd16_at(3'd5, "pc_inc", 16'h0001);

    // Out-of-range word write and IDU have no effect; out-of-range reads zero.
    wr16_en = 1'b1; wr16_sel = 3'd6; wr16_data = 16'h5555;
    idu_en = 1'b1; idu_sel = 3'd7; #1;
    chk("oor_idu_addr", idu_addr, 16'h0000);
    tick(); idle();
    rd16_at(3'd6, "oor_read", 16'h0000);
    rd16_at(3'd4, "oor_sp", 16'hFFFD);
    rd16_at(3'd5, "oor_pc", 16'h0001);

    // Enable low masks every strobe.
    en = 1'b0;
    wr8_en = 1'b1; wr8_sel = 3'd0; wr8_data = 8'h77;
    wr16_en = 1'b1; wr16_sel = 3'd1; wr16_data = 16'h9999;
    idu_en = 1'b1; idu_sel = 3'd3; idu_dec = 1'b0;
    tick(); idle();
    rd8a_sel = 3'd0; #1;
    chk("dis_wz_hi", {8'h00, rd8a}, 16'h0000);
    rd16_at(3'd1, "dis_bc", 16'h1234);
    rd16_at(3'd3, "dis_hl", 16'hAAEF);

    // Reset with enable low.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd16_at(3'd4, "rst2_sp", 16'hFFFE);
    rd16_at(3'd3, "rst2_hl", 16'h0000);
    rd16_at(3'd5, "rst2_pc", 16'h0000);

    // Same-cycle read of a byte being written.
    en = 1'b1;
    wr8_en = 1'b1; wr8_sel = 3'd5; wr8_data = 8'h5A;
    rd8a_sel = 3'd5; #1;
`ifdef REGFILE_BYPASS_EN
    chk("same_cycle_e", {8'h00, rd8a}, 16'h005A);
`else
    chk("same_cycle_e", {8'h00, rd8a}, 16'h0000);
`endif
    tick(); idle();
    #1;
    chk("after_e", {8'h00, rd8a}, 16'h005A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
